// File: rtl/trackball_quad_decoder_pkg.sv
// Shared types and decode helpers for the trackball quadrature decoder.
package trackball_pkg;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_POS     = 2'd1,
    STEP_NEG     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  localparam logic MODE_QUAD   = 1'b0;
  localparam logic MODE_DIRCLK = 1'b1;

  // Glitch-filter counter width; covers FILTER_LEN up to 15.
  localparam int unsigned FLT_CNT_W = 4;

  // Gray-code step between two {A,B} samples: 00->01->11->10->00 is positive.
  function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                return STEP_NONE;
    if ((cur ^ prev) == 2'b11)      return STEP_ILLEGAL;
    if (cur == {prev[0], ~prev[1]}) return STEP_POS;
    return STEP_NEG;
  endfunction

  // Cocktail flip swaps the sign of a real step, leaves none/illegal alone.
  function automatic step_t flip_step(input step_t s, input logic flip);
    if (flip && (s == STEP_POS)) return STEP_NEG;
    if (flip && (s == STEP_NEG)) return STEP_POS;
    return s;
  endfunction

endpackage

// File: rtl/trackball_quad_decoder_if.sv
// Snapshot handshake between the game CPU read path and the decoder.
interface trackball_quad_decoder_if #(
  parameter int unsigned CNT_W = 4
) ();

  logic             snap_req_i;
  logic             clr_on_snap_i;
  logic             snap_valid_o;
  logic [CNT_W-1:0] snap_x_o;
  logic [CNT_W-1:0] snap_y_o;

  modport master (
    output snap_req_i,
    output clr_on_snap_i,
    input  snap_valid_o,
    input  snap_x_o,
    input  snap_y_o
  );

  modport slave (
    input  snap_req_i,
    input  clr_on_snap_i,
    output snap_valid_o,
    output snap_x_o,
    output snap_y_o
  );

endinterface

// File: rtl/trackball_quad_decoder_quad_axis.sv
// One trackball axis: 2-FF sync, per-bit glitch filter, step decode, position counter.
module quad_axis
  import trackball_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             armed_i,
  input  logic             mode_i,
  input  logic             flip_i,
  input  logic             clr_i,
  output step_t            step_c_o,
  output logic [CNT_W-1:0] count_o
);

  // Bit 1 carries A, bit 0 carries B.
  logic [1:0]                sync1_q, sync2_q;
  logic [1:0]                filt_q, filt_d;
  logic [1:0]                prev_q, prev_d;
  logic [1:0][FLT_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]          count_q, count_d;
  step_t                     raw_step;

  // Filter: accept a bit once it has differed for FILTER_LEN cycles; track directly while unarmed.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    prev_d = filt_q;
    if (!armed_i) begin
      filt_d = sync2_q;
      prev_d = sync2_q;
      fcnt_d = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_d[i] = '0;
        end else if (FLT_CNT_W'(fcnt_q[i] + FLT_CNT_W'(1)) == FLT_CNT_W'(FILTER_LEN)) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + FLT_CNT_W'(1);
        end
      end
    end
  end

  // Step decode from previous vs current filtered sample, then counter update.
  always_comb begin
    raw_step = STEP_NONE;
    if (mode_i == MODE_DIRCLK) begin
      if (prev_q[0] != filt_q[0]) raw_step = filt_q[1] ? STEP_POS : STEP_NEG;
    end else begin
      raw_step = quad_step(prev_q, filt_q);
    end
    step_c_o = armed_i ? flip_step(raw_step, flip_i) : STEP_NONE;

    count_d = clr_i ? '0 : count_q;
    case (step_c_o)
      STEP_POS: count_d = count_d + CNT_W'(1);
      STEP_NEG: count_d = count_d - CNT_W'(1);
      default:  count_d = count_d;
    endcase
  end

  // Axis state registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      fcnt_q  <= '0;
      count_q <= '0;
    end else begin
      sync1_q <= {a_i, b_i};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      fcnt_q  <= fcnt_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/trackball_quad_decoder.sv
// Two-axis trackball decoder: arming, snapshot capture, direction and error aggregation.
module trackball_quad_decoder
  import trackball_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned ARM_LEN    = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [1:0]               quad_a_i,
  input  logic [1:0]               quad_b_i,
  input  logic                     dirclk_mode_i,
  input  logic                     flip_i,
  trackball_quad_decoder_if.slave  snap_if,
  output logic [1:0]               dir_o,
  output logic [CNT_W-1:0]         count_x_o,
  output logic [CNT_W-1:0]         count_y_o,
  output logic                     err_o,
  output logic [7:0]               err_cnt_o
);

  localparam int unsigned ARM_W = $clog2(ARM_LEN + 1);

  logic             armed_q, armed_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             mode_q;
  logic             snap_valid_q;
  logic [CNT_W-1:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [1:0]       dir_q, dir_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             clr_c;
  step_t            step_x_c, step_y_c;
  logic [CNT_W-1:0] cnt_x, cnt_y;

  assign clr_c = snap_if.snap_req_i & snap_if.clr_on_snap_i;

  quad_axis #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W)) u_axis_x (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .a_i      (quad_a_i[0]),
    .b_i      (quad_b_i[0]),
    .armed_i  (armed_q),
    .mode_i   (mode_q),
    .flip_i   (flip_i),
    .clr_i    (clr_c),
    .step_c_o (step_x_c),
    .count_o  (cnt_x)
  );

  quad_axis #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W)) u_axis_y (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .a_i      (quad_a_i[1]),
    .b_i      (quad_b_i[1]),
    .armed_i  (armed_q),
    .mode_i   (mode_q),
    .flip_i   (flip_i),
    .clr_i    (clr_c),
    .step_c_o (step_y_c),
    .count_o  (cnt_y)
  );

  // Arming window, restarted on any decode-mode change; snapshot, dir and error next-state.
  always_comb begin
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;
    if (dirclk_mode_i != mode_q) begin
      armed_d   = 1'b0;
      arm_cnt_d = '0;
    end else if (!armed_q) begin
      if (arm_cnt_q == ARM_W'(ARM_LEN - 1)) begin
        armed_d   = 1'b1;
        arm_cnt_d = '0;
      end else begin
        arm_cnt_d = arm_cnt_q + ARM_W'(1);
      end
    end

    snap_x_d = snap_x_q;
    snap_y_d = snap_y_q;
    if (snap_if.snap_req_i) begin
      snap_x_d = cnt_x;
      snap_y_d = cnt_y;
    end

    dir_d = dir_q;
    if (step_x_c == STEP_POS) dir_d[0] = 1'b1;
    if (step_x_c == STEP_NEG) dir_d[0] = 1'b0;
    if (step_y_c == STEP_POS) dir_d[1] = 1'b1;
    if (step_y_c == STEP_NEG) dir_d[1] = 1'b0;

    err_d     = (step_x_c == STEP_ILLEGAL) || (step_y_c == STEP_ILLEGAL);
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Top-level registers; reset also drops any pending snapshot.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      armed_q      <= 1'b0;
      arm_cnt_q    <= '0;
      mode_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_x_q     <= '0;
      snap_y_q     <= '0;
      dir_q        <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      armed_q      <= armed_d;
      arm_cnt_q    <= arm_cnt_d;
      mode_q       <= dirclk_mode_i;
      snap_valid_q <= snap_if.snap_req_i;
      snap_x_q     <= snap_x_d;
      snap_y_q     <= snap_y_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign snap_if.snap_valid_o = snap_valid_q;
  assign snap_if.snap_x_o     = snap_x_q;
  assign snap_if.snap_y_o     = snap_y_q;
  assign dir_o                = dir_q;
  assign count_x_o            = cnt_x;
  assign count_y_o            = cnt_y;
  assign err_o                = err_q;
  assign err_cnt_o            = err_cnt_q;

endmodule

// File: tb/tb_trackball_quad_decoder.sv
// Directed bench for trackball_quad_decoder with default parameters.
module tb_trackball_quad_decoder;

  logic       clk_sys;
  logic       reset;
  logic [1:0] quad_a;
  logic [1:0] quad_b;
  logic       dirclk_mode;
  logic       flip;
  logic [1:0] dir;
  logic [3:0] count_x, count_y;
  logic       err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  trackball_quad_decoder_if #(.CNT_W(4)) snap_if ();

  trackball_quad_decoder #(.FILTER_LEN(4), .CNT_W(4), .ARM_LEN(8)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .quad_a_i      (quad_a),
    .quad_b_i      (quad_b),
    .dirclk_mode_i (dirclk_mode),
    .flip_i        (flip),
    .snap_if       (snap_if.slave),
    .dir_o         (dir),
    .count_x_o     (count_x),
    .count_y_o     (count_y),
    .err_o         (err),
    .err_cnt_o     (err_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step_clk(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic set_x(input logic [1:0] ab);
    quad_a[0] = ab[1];
    quad_b[0] = ab[0];
  endtask

  task automatic set_y(input logic [1:0] ab);
    quad_a[1] = ab[1];
    quad_b[1] = ab[0];
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cx"}, 32'(count_x), 32'd0);
    check_eq({tag, "_cy"}, 32'(count_y), 32'd0);
    check_eq({tag, "_dir"}, 32'(dir), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_ecnt"}, 32'(err_cnt), 32'd0);
    check_eq({tag, "_sv"}, 32'(snap_if.snap_valid_o), 32'd0);
    check_eq({tag, "_sx"}, 32'(snap_if.snap_x_o), 32'd0);
    check_eq({tag, "_sy"}, 32'(snap_if.snap_y_o), 32'd0);
  endtask

  logic [1:0] fwd_seq [4];
  logic [1:0] rev_seq [4];

  initial begin
    fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00};

    reset = 1'b1;
    quad_a = '0;
    quad_b = '0;
    dirclk_mode = 1'b0;
    flip = 1'b0;
    snap_if.snap_req_i = 1'b0;
    snap_if.clr_on_snap_i = 1'b0;
    step_clk(3);
    check_all_zero("reset");
    reset = 1'b0;
    step_clk(20);

    // Forward quadrature on X, with latency probe on the first edge.
    set_x(fwd_seq[0]);
    step_clk(6);
    check_eq("lat_before", 32'(count_x), 32'd0);
    step_clk(1);
    check_eq("lat_at7", 32'(count_x), 32'd1);
    step_clk(3);
    for (int i = 1; i < 4; i++) begin
      set_x(fwd_seq[i]);
      step_clk(10);
    end
    check_eq("fwd_cnt", 32'(count_x), 32'd4);
    check_eq("fwd_dir", 32'(dir[0]), 32'd1);

    // Reverse with flip counts up; reverse without flip counts down.
    flip = 1'b1;
    for (int i = 0; i < 4; i++) begin set_x(rev_seq[i]); step_clk(10); end
    check_eq("flip_cnt", 32'(count_x), 32'd8);
    check_eq("flip_dir", 32'(dir[0]), 32'd1);
    flip = 1'b0;
    for (int i = 0; i < 4; i++) begin set_x(rev_seq[i]); step_clk(10); end
    check_eq("rev_cnt", 32'(count_x), 32'd4);
    check_eq("rev_dir", 32'(dir[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin set_x(rev_seq[i]); step_clk(10); end
    check_eq("rev_cnt0", 32'(count_x), 32'd0);

    // Illegal jump on Y.
    set_y(2'b11);
    step_clk(7);
    check_eq("ill_err", 32'(err), 32'd1);
    check_eq("ill_ecnt", 32'(err_cnt), 32'd1);
    check_eq("ill_cy", 32'(count_y), 32'd0);
    step_clk(1);
    check_eq("ill_err_pulse", 32'(err), 32'd0);
    step_clk(2);
    for (int i = 0; i < 299; i++) begin
      set_y((i % 2 == 0) ? 2'b00 : 2'b11);
      step_clk(8);
    end
    check_eq("ill_sat", 32'(err_cnt), 32'd255);
    check_eq("ill_sat_cy", 32'(count_y), 32'd0);

    // Dir/clk mode: A=0, 17 B edges count down.
    dirclk_mode = 1'b1;
    step_clk(12);
    check_eq("mode_keep", 32'(count_x), 32'd0);
    for (int i = 0; i < 17; i++) begin
      quad_b[0] = ~quad_b[0];
      step_clk(8);
    end
    check_eq("dc_cnt", 32'(count_x), 32'd15);
    check_eq("dc_dir", 32'(dir[0]), 32'd0);
    check_eq("dc_noerr", 32'(err), 32'd0);
    quad_b[0] = ~quad_b[0];
    step_clk(3);
    quad_b[0] = ~quad_b[0];
    step_clk(12);
    check_eq("glitch", 32'(count_x), 32'd15);

    // Back to quadrature; X now at 01. Six +1 steps bring 15 to 5.
    dirclk_mode = 1'b0;
    step_clk(12);
    for (int i = 0; i < 6; i++) begin
      set_x(fwd_seq[(i + 1) % 4]);
      step_clk(10);
    end
    check_eq("pre_snap", 32'(count_x), 32'd5);

    // Snapshot with clear, coincident with a +1 step.
    set_x(2'b00);
    step_clk(6);
    snap_if.snap_req_i = 1'b1;
    snap_if.clr_on_snap_i = 1'b1;
    step_clk(1);
    snap_if.snap_req_i = 1'b0;
    snap_if.clr_on_snap_i = 1'b0;
    check_eq("snap_valid", 32'(snap_if.snap_valid_o), 32'd1);
    check_eq("snap_x", 32'(snap_if.snap_x_o), 32'd5);
    check_eq("snap_y", 32'(snap_if.snap_y_o), 32'd0);
    check_eq("snap_clr_cnt", 32'(count_x), 32'd1);
    step_clk(1);
    check_eq("snap_pulse", 32'(snap_if.snap_valid_o), 32'd0);

    // Back-to-back snapshots without clear.
    snap_if.snap_req_i = 1'b1;
    step_clk(1);
    check_eq("b2b_v1", 32'(snap_if.snap_valid_o), 32'd1);
    check_eq("b2b_x1", 32'(snap_if.snap_x_o), 32'd1);
    step_clk(1);
    snap_if.snap_req_i = 1'b0;
    check_eq("b2b_v2", 32'(snap_if.snap_valid_o), 32'd1);
    step_clk(1);
    check_eq("b2b_end", 32'(snap_if.snap_valid_o), 32'd0);
    check_eq("b2b_cnt", 32'(count_x), 32'd1);

    // Reset mid-sequence with a pending snapshot and inputs at 11.
    set_x(2'b11);
    set_y(2'b11);
    step_clk(3);
    reset = 1'b1;
    snap_if.snap_req_i = 1'b1;
    step_clk(1);
    snap_if.snap_req_i = 1'b0;
    step_clk(1);
    check_all_zero("midrst");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_clk(1);
      check_eq("arm_noerr", 32'(err), 32'd0);
      check_eq("arm_cnt", 32'(count_x), 32'd0);
      check_eq("arm_nosnap", 32'(snap_if.snap_valid_o), 32'd0);
    end
    set_x(2'b10);
    step_clk(10);
    check_eq("post_rst_cnt", 32'(count_x), 32'd1);
    check_eq("post_rst_dir", 32'(dir), 32'd1);
    check_eq("post_rst_ecnt", 32'(err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
